// File: rtl/cmos_bringup_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cmos_bringup_ctrl_pkg : state codes and constant helpers for the OV5640 bring-up sequencer
// Revision: 1.0
// ============================================================================
package cmos_bringup_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_PWDN   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_CFG    = 3'd3,
    S_LOCK   = 3'd4,
    S_RUN    = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmos_vsync_sync.sv
`default_nettype none
// ============================================================================
// cmos_vsync_sync : two-flop synchroniser for raw sensor vsync plus rising-edge pulse
// Revision: 1.0
// ============================================================================
module cmos_vsync_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_o
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= async_in;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  // Built only from flops, so the pulse is one clean clk wide
  assign rise_o = r_sync & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/cmos_bringup_ctrl.sv
`default_nettype none
// ============================================================================
// cmos_bringup_ctrl : OV5640 power-up, config supervision and vsync lock sequencer.
// Optional frame counter output enabled by macro CMOS_BRINGUP_FRAME_CNT_EN.
// Revision: 1.0
// ============================================================================
module cmos_bringup_ctrl
  import cmos_bringup_ctrl_pkg::*;
#(
  parameter int PWDN_CYCLES   = 50_000,
  parameter int RST_CYCLES    = 50_000,
  parameter int SETTLE_CYCLES = 1_000_000,
  parameter int MAX_RETRY     = 3,
  parameter int LOCK_FRAMES   = 4,
  parameter int VS_TIMEOUT    = 4_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               cfg_done,
  input  logic               cfg_error,
  input  logic               cmos_vsync,
  output logic               cmos_pwdn,
  output logic               cmos_rst_n,
  output logic               cfg_rst,
  output logic               stream_en,
  output logic               locked,
  output logic               fail,
  output logic [3:0]         retry_cnt,
  output logic [STATE_W-1:0] state_o
`ifdef CMOS_BRINGUP_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int c_max_cyc = max_int(max_int(PWDN_CYCLES, RST_CYCLES),
                                     max_int(SETTLE_CYCLES, VS_TIMEOUT));
  localparam int c_cnt_w   = $clog2(c_max_cyc) + 1;
  localparam int c_edge_w  = $clog2(LOCK_FRAMES) + 1;

  localparam logic [c_cnt_w-1:0]  c_pwdn_last   = c_cnt_w'(PWDN_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_to_last     = c_cnt_w'(VS_TIMEOUT - 1);
  localparam logic [c_edge_w-1:0] c_edge_last   = c_edge_w'(LOCK_FRAMES - 1);

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_dly_cnt;
  logic [c_cnt_w-1:0]  r_to_cnt;
  logic [c_edge_w-1:0] r_edge_cnt;
  logic [3:0]          r_retry;

  logic       w_vs_rise;
  logic       w_in_watch;
  logic       w_last_edge;
  logic       w_retry_evt;
  logic       w_retry_fail;
  logic [3:0] w_retry_nx;

  cmos_vsync_sync u_vsync_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (cmos_vsync),
    .rise_o   (w_vs_rise)
  );

  assign w_in_watch   = (r_state == S_LOCK) || (r_state == S_RUN);
  assign w_last_edge  = (r_edge_cnt == c_edge_last);
  assign w_retry_nx   = r_retry + 4'd1;
  assign w_retry_fail = (w_retry_nx >= 4'(MAX_RETRY));
  // Config error (beats a simultaneous done) or a vsync gap; an edge on the last timeout cycle still counts
  assign w_retry_evt  = ((r_state == S_CFG) && cfg_error) ||
                        (w_in_watch && !w_vs_rise && (r_to_cnt == c_to_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_PWDN;
      r_dly_cnt  <= '0;
      r_to_cnt   <= '0;
      r_edge_cnt <= '0;
      r_retry    <= '0;
      cmos_pwdn  <= 1'b1;
      cmos_rst_n <= 1'b0;
      cfg_rst    <= 1'b1;
      stream_en  <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      // Pin outputs trail the state register by one clock; stream_en is gated on leaving RUN instead
      cmos_pwdn  <= (r_state == S_PWDN) || (r_state == S_FAIL);
      cmos_rst_n <= (r_state inside {S_SETTLE, S_CFG, S_LOCK, S_RUN});
      cfg_rst    <= (r_state inside {S_PWDN, S_RST, S_SETTLE, S_FAIL});
      locked     <= (r_state == S_RUN);
      fail       <= (r_state == S_FAIL);
      stream_en  <= 1'b0;

      if (restart) begin
        r_state    <= S_PWDN;
        r_dly_cnt  <= '0;
        r_to_cnt   <= '0;
        r_edge_cnt <= '0;
        r_retry    <= '0;
      end else if (w_retry_evt) begin
        r_state    <= w_retry_fail ? S_FAIL : S_PWDN;
        r_retry    <= w_retry_nx;
        r_dly_cnt  <= '0;
        r_to_cnt   <= '0;
        r_edge_cnt <= '0;
      end else begin
        case (r_state)
          S_PWDN: begin
            if (r_dly_cnt == c_pwdn_last) begin
              r_dly_cnt <= '0;
              r_state   <= S_RST;
            end else begin
              r_dly_cnt <= r_dly_cnt + 1'b1;
            end
          end
          S_RST: begin
            if (r_dly_cnt == c_rst_last) begin
              r_dly_cnt <= '0;
              r_state   <= S_SETTLE;
            end else begin
              r_dly_cnt <= r_dly_cnt + 1'b1;
            end
          end
          S_SETTLE: begin
            if (r_dly_cnt == c_settle_last) begin
              r_dly_cnt <= '0;
              r_state   <= S_CFG;
            end else begin
              r_dly_cnt <= r_dly_cnt + 1'b1;
            end
          end
          S_CFG: begin
            if (cfg_done) begin
              r_state    <= S_LOCK;
              r_to_cnt   <= '0;
              r_edge_cnt <= '0;
            end
          end
          S_LOCK: begin
            if (w_vs_rise) begin
              r_to_cnt <= '0;
              if (w_last_edge) begin
                r_state <= S_RUN;
              end else begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
              end
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          S_RUN: begin
            stream_en <= 1'b1;
            if (w_vs_rise) begin
              r_to_cnt <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          S_FAIL: begin
            r_state <= S_FAIL;
          end
          default: begin
            r_state <= S_PWDN;
          end
        endcase
      end
    end
  end

  assign retry_cnt = r_retry;
  assign state_o   = r_state;

`ifdef CMOS_BRINGUP_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // The edge that completes the lock is the reference point, not a counted frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (!restart && w_vs_rise) begin
      if ((r_state == S_LOCK) && w_last_edge) begin
        r_frame_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire
